// File: rtl/pdm_cic_decimator.sv
// pdm_cic_decimator: one-bit PDM stream to signed PCM via an ORDER-stage CIC decimator (R = 2^DEC_LOG2).
// Optional build macro PDM_CIC_DC_BLOCK_EN inserts a first-order DC blocker ahead of saturation (+1 cycle).
module pdm_cic_decimator #(
    parameter int ORDER     = 3,
    parameter int DEC_LOG2  = 4,
    parameter int OUT_WIDTH = 12,
    parameter int DC_SHIFT  = 8
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        pdm_in,
    input  logic                        tick_in,
    output logic signed [OUT_WIDTH-1:0] pcm_out,
    output logic                        pcm_valid,
    output logic                        warm
);
    // Strobe semantics: tick_in is a one-cycle step strobe (pdm_in sampled with it, never dropped);
    // pcm_valid is a one-cycle strobe with no back-pressure, and pcm_out holds between strobes.
    localparam int W     = ORDER * DEC_LOG2 + 2;
    localparam int SHIFT = ORDER * DEC_LOG2 + 1 - OUT_WIDTH;
    localparam int DW    = OUT_WIDTH + 2;
    localparam int SW    = W + 2;
    localparam logic signed [SW-1:0] SAT_MAX = SW'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
    localparam logic signed [SW-1:0] SAT_MIN = SW'(-(64'sd1 <<< (OUT_WIDTH - 1)));

    if (ORDER < 1 || ORDER > 5 || DEC_LOG2 < 1 || DEC_LOG2 > 8 || OUT_WIDTH < 2 ||
        ORDER * DEC_LOG2 + 1 < OUT_WIDTH || DC_SHIFT < 1 || DC_SHIFT >= DW) begin : g_param_check
        $error("pdm_cic_decimator: illegal parameter set");
    end

    typedef enum logic {
        S_WARMUP = 1'b0,
        S_RUN    = 1'b1
    } state_t;

    logic signed [W-1:0]         integ      [ORDER];
    logic signed [W-1:0]         integ_next [ORDER];
    logic signed [W-1:0]         comb_dly   [ORDER];
    logic signed [W-1:0]         comb_x     [ORDER+1];
    logic signed [W-1:0]         step;
    logic signed [W-1:0]         scaled;
    logic [DEC_LOG2-1:0]         phase;
    logic                        dec_stb;
    state_t                      state;
    logic [2:0]                  warm_cnt;
    logic signed [SW-1:0]        sat_src;
    logic signed [OUT_WIDTH-1:0] sat_val;
    logic                        out_stb;

    // Integrators ripple within one tick so the last stage already includes the current bit.
    always_comb begin
        step          = pdm_in ? W'(1) : '1;
        integ_next[0] = integ[0] + step;
        for (int k = 1; k < ORDER; k++)
            integ_next[k] = integ[k] + integ_next[k-1];
    end

    always_comb begin
        comb_x[0] = integ[ORDER-1];
        for (int k = 0; k < ORDER; k++)
            comb_x[k+1] = comb_x[k] - comb_dly[k];
    end

    assign scaled = comb_x[ORDER] >>> SHIFT;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int k = 0; k < ORDER; k++)
                integ[k] <= '0;
            phase   <= '0;
            dec_stb <= 1'b0;
        end else begin
            dec_stb <= tick_in && (phase == '1);
            if (tick_in) begin
                phase <= phase + DEC_LOG2'(1);
                for (int k = 0; k < ORDER; k++)
                    integ[k] <= integ_next[k];
            end
        end
    end

`ifdef PDM_CIC_DC_BLOCK_EN
    logic signed [DW-1:0] dc_x;
    logic signed [DW-1:0] dc_x_prev;
    logic signed [DW-1:0] dc_y_prev;
    logic signed [DW-1:0] dc_y;
    logic                 run_stb;

    assign dc_y    = dc_x - dc_x_prev + dc_y_prev - (dc_y_prev >>> DC_SHIFT);
    assign sat_src = SW'(dc_y);
    assign out_stb = run_stb;
`else
    assign sat_src = SW'(scaled);
    assign out_stb = dec_stb && (state == S_RUN);
`endif

    always_comb begin
        if (sat_src > SAT_MAX)
            sat_val = SAT_MAX[OUT_WIDTH-1:0];
        else if (sat_src < SAT_MIN)
            sat_val = SAT_MIN[OUT_WIDTH-1:0];
        else
            sat_val = sat_src[OUT_WIDTH-1:0];
    end

    // Warm-up FSM: comb delays fill during WARMUP, samples are only emitted in RUN.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state     <= S_WARMUP;
            warm_cnt  <= '0;
            for (int k = 0; k < ORDER; k++)
                comb_dly[k] <= '0;
            pcm_out   <= '0;
            pcm_valid <= 1'b0;
            warm      <= 1'b0;
`ifdef PDM_CIC_DC_BLOCK_EN
            dc_x      <= '0;
            dc_x_prev <= '0;
            dc_y_prev <= '0;
            run_stb   <= 1'b0;
`endif
        end else begin
            if (dec_stb) begin
                for (int k = 0; k < ORDER; k++)
                    comb_dly[k] <= comb_x[k];
                if (state == S_WARMUP) begin
                    warm_cnt <= warm_cnt + 3'd1;
                    if (warm_cnt == 3'(ORDER - 1))
                        state <= S_RUN;
                end
            end
`ifdef PDM_CIC_DC_BLOCK_EN
            run_stb <= dec_stb && (state == S_RUN);
            if (dec_stb && (state == S_RUN))
                dc_x <= DW'(scaled);
            if (run_stb) begin
                dc_x_prev <= dc_x;
                dc_y_prev <= dc_y;
            end
`endif
            pcm_valid <= out_stb;
            if (out_stb) begin
                pcm_out <= sat_val;
                warm    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pdm_cic_decimator.sv
// Directed bench for pdm_cic_decimator at default parameters (ORDER=3, R=16, OUT_WIDTH=12).
`timescale 1ns/1ps
module tb_pdm_cic_decimator;
  localparam int R   = 16;
  localparam int NH  = 3 * (R - 1) + 1;
`ifdef PDM_CIC_DC_BLOCK_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  logic pdm_in = 1'b0;
  logic tick_in = 1'b0;
  logic signed [11:0] pcm_out;
  logic pcm_valid;
  logic warm;

  int tests_run = 0;
  int tests_failed = 0;

  // clock / reset
  always #5 clk_in = ~clk_in;

  pdm_cic_decimator #(
    .ORDER(3), .DEC_LOG2(4), .OUT_WIDTH(12), .DC_SHIFT(8)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .pdm_in(pdm_in), .tick_in(tick_in),
    .pcm_out(pcm_out), .pcm_valid(pcm_valid), .warm(warm)
  );

  // output log, sampled on the falling edge
  int cyc = 0;
  logic [11:0] val_q[$];
  int vcyc_q[$];
  logic vwarm_q[$];
  int tick_cyc_q[$];
  logic stim_q[$];
  logic [11:0] exp_q[$];
  int warm_rise_cyc = -1;
  logic warm_d = 1'b0;

  always @(negedge clk_in) begin
    cyc = cyc + 1;
    if (pcm_valid === 1'b1) begin
      val_q.push_back(pcm_out);
      vcyc_q.push_back(cyc);
      vwarm_q.push_back(warm);
    end
    if (warm === 1'b1 && warm_d !== 1'b1 && warm_rise_cyc < 0) warm_rise_cyc = cyc;
    warm_d = warm;
  end

  task automatic clear_log();
    val_q.delete(); vcyc_q.delete(); vwarm_q.delete();
    tick_cyc_q.delete(); stim_q.delete(); exp_q.delete();
    warm_rise_cyc = -1;
  endtask

  task automatic apply_reset();
    @(negedge clk_in); #1;
    rst_in = 1'b1; tick_in = 1'b0;
    repeat (3) @(negedge clk_in);
    #1 rst_in = 1'b0;
    clear_log();
  endtask

  // pattern: 0 all zeros, 1 all ones, 2 alternating 1,0, 3 random
  task automatic drive_ticks(input int n, input int gap, input int pattern);
    logic b;
    for (int i = 0; i < n; i++) begin
      case (pattern)
        0: b = 1'b0;
        1: b = 1'b1;
        2: b = (i % 2 == 0);
        default: b = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk_in); #1;
      tick_in = 1'b1; pdm_in = b;
      stim_q.push_back(b);
      tick_cyc_q.push_back(cyc);
      if (gap > 1) begin
        @(negedge clk_in); #1;
        tick_in = 1'b0;
        repeat (gap - 2) @(negedge clk_in);
      end
    end
    if (gap == 1) begin
      @(negedge clk_in); #1;
      tick_in = 1'b0;
    end
  endtask

  task automatic test_reset();
    #1 rst_in = 1'b1;
    repeat (2) @(negedge clk_in);
    tests_run++;
    if (pcm_out !== 12'sd0) begin
      tests_failed++; $display("FAIL reset_pcm_out: got %0d expected 0", pcm_out);
    end
    tests_run++;
    if (pcm_valid !== 1'b0) begin
      tests_failed++; $display("FAIL reset_pcm_valid: got %b expected 0", pcm_valid);
    end
    tests_run++;
    if (warm !== 1'b0) begin
      tests_failed++; $display("FAIL reset_warm: got %b expected 0", warm);
    end
    #1 rst_in = 1'b0;
    clear_log();
  endtask

  task automatic test_const_one();
    apply_reset();
    drive_ticks(6 * R, 32, 1);
    repeat (8) @(negedge clk_in);
    tests_run++;
    if (val_q.size() != 3) begin
      tests_failed++; $display("FAIL const1_count: got %0d expected 3", val_q.size());
    end
    if (val_q.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        tests_run++;
        if (val_q[i] !== 12'h7FF) begin
          tests_failed++; $display("FAIL const1_val[%0d]: got %0d expected 2047", i, $signed(val_q[i]));
        end
        tests_run++;
        if (vwarm_q[i] !== 1'b1) begin
          tests_failed++; $display("FAIL const1_warm[%0d]: got %b expected 1", i, vwarm_q[i]);
        end
      end
      tests_run++;
      if (vcyc_q[0] - tick_cyc_q[4*R-1] != LAT) begin
        tests_failed++; $display("FAIL const1_latency: got %0d expected %0d", vcyc_q[0] - tick_cyc_q[4*R-1], LAT);
      end
      for (int i = 1; i < 3; i++) begin
        tests_run++;
        if (vcyc_q[i] - vcyc_q[i-1] != 32 * R) begin
          tests_failed++; $display("FAIL const1_spacing[%0d]: got %0d expected %0d", i, vcyc_q[i] - vcyc_q[i-1], 32 * R);
        end
      end
      tests_run++;
      if (warm_rise_cyc != vcyc_q[0]) begin
        tests_failed++; $display("FAIL const1_warm_rise: got cycle %0d expected %0d", warm_rise_cyc, vcyc_q[0]);
      end
    end
  endtask

  task automatic test_const_zero();
    apply_reset();
    drive_ticks(5 * R, 32, 0);
    repeat (8) @(negedge clk_in);
    tests_run++;
    if (val_q.size() != 2) begin
      tests_failed++; $display("FAIL const0_count: got %0d expected 2", val_q.size());
    end
    for (int i = 0; i < val_q.size(); i++) begin
      tests_run++;
      if (val_q[i] !== 12'h800) begin
        tests_failed++; $display("FAIL const0_val[%0d]: got %0d expected -2048", i, $signed(val_q[i]));
      end
    end
  endtask

  task automatic test_alternating();
    apply_reset();
    drive_ticks(6 * R, 32, 2);
    repeat (8) @(negedge clk_in);
    tests_run++;
    if (val_q.size() != 3) begin
      tests_failed++; $display("FAIL alt_count: got %0d expected 3", val_q.size());
    end
    for (int i = 0; i < val_q.size(); i++) begin
      tests_run++;
      if (val_q[i] !== 12'h000) begin
        tests_failed++; $display("FAIL alt_val[%0d]: got %0d expected 0", i, $signed(val_q[i]));
      end
    end
  endtask

  // Reference: direct convolution with the 3-fold boxcar kernel, no integrators involved.
  task automatic test_random_fast();
    int h[NH];
    int nframes;
    int raw;
    int sc;
    int spacing_err;
    for (int k = 0; k < NH; k++) h[k] = 0;
    for (int a = 0; a < R; a++)
      for (int b = 0; b < R; b++)
        for (int c = 0; c < R; c++)
          h[a + b + c]++;
    apply_reset();
    drive_ticks(10000, 1, 3);
    repeat (8) @(negedge clk_in);
    nframes = 10000 / R;
    for (int n = 4; n <= nframes; n++) begin
      raw = 0;
      for (int k = 0; k < NH; k++)
        raw += h[k] * (stim_q[n*R - 1 - k] ? 1 : -1);
      sc = raw >>> 1;
      if (sc > 2047) sc = 2047;
      if (sc < -2048) sc = -2048;
      exp_q.push_back(12'(sc));
    end
    tests_run++;
    if (val_q.size() != exp_q.size()) begin
      tests_failed++; $display("FAIL rand_count: got %0d expected %0d", val_q.size(), exp_q.size());
    end
    for (int i = 0; i < val_q.size() && i < exp_q.size(); i++) begin
      tests_run++;
      if (val_q[i] !== exp_q[i]) begin
        tests_failed++; $display("FAIL rand_val[%0d]: got %0d expected %0d", i, $signed(val_q[i]), $signed(exp_q[i]));
      end
    end
    spacing_err = 0;
    for (int i = 1; i < vcyc_q.size(); i++)
      if (vcyc_q[i] - vcyc_q[i-1] != R) spacing_err++;
    tests_run++;
    if (spacing_err != 0) begin
      tests_failed++; $display("FAIL rand_spacing: got %0d bad gaps expected 0", spacing_err);
    end
    if (vcyc_q.size() > 0) begin
      tests_run++;
      if (vcyc_q[0] - tick_cyc_q[4*R-1] != LAT) begin
        tests_failed++; $display("FAIL rand_latency: got %0d expected %0d", vcyc_q[0] - tick_cyc_q[4*R-1], LAT);
      end
    end
  endtask

  task automatic test_mid_reset();
    apply_reset();
    drive_ticks(4 * R + 7, 32, 1);
    tests_run++;
    if (val_q.size() != 1) begin
      tests_failed++; $display("FAIL midrst_pre_count: got %0d expected 1", val_q.size());
    end
    @(negedge clk_in); #1;
    rst_in = 1'b1;
    #1;
    tests_run++;
    if (pcm_out !== 12'sd0) begin
      tests_failed++; $display("FAIL midrst_pcm_out: got %0d expected 0", pcm_out);
    end
    tests_run++;
    if (warm !== 1'b0) begin
      tests_failed++; $display("FAIL midrst_warm: got %b expected 0", warm);
    end
    repeat (2) @(negedge clk_in);
    #1 rst_in = 1'b0;
    clear_log();
    drive_ticks(3 * R, 32, 1);
    tests_run++;
    if (val_q.size() != 0) begin
      tests_failed++; $display("FAIL midrst_warmup_count: got %0d expected 0", val_q.size());
    end
    drive_ticks(R, 32, 1);
    repeat (8) @(negedge clk_in);
    tests_run++;
    if (val_q.size() != 1) begin
      tests_failed++; $display("FAIL midrst_post_count: got %0d expected 1", val_q.size());
    end
    if (val_q.size() == 1) begin
      tests_run++;
      if (val_q[0] !== 12'h7FF) begin
        tests_failed++; $display("FAIL midrst_val: got %0d expected 2047", $signed(val_q[0]));
      end
      tests_run++;
      if (vcyc_q[0] - tick_cyc_q[4*R-1] != LAT) begin
        tests_failed++; $display("FAIL midrst_latency: got %0d expected %0d", vcyc_q[0] - tick_cyc_q[4*R-1], LAT);
      end
    end
  endtask

`ifdef PDM_CIC_DC_BLOCK_EN
  // Expected: 2048 -> sat 2047; 2040; 2040 - (2040 >>> 8) = 2033.
  task automatic test_dc_block();
    logic [11:0] dc_exp[3];
    dc_exp[0] = 12'd2047; dc_exp[1] = 12'd2040; dc_exp[2] = 12'd2033;
    apply_reset();
    drive_ticks(6 * R, 32, 1);
    repeat (8) @(negedge clk_in);
    tests_run++;
    if (val_q.size() != 3) begin
      tests_failed++; $display("FAIL dc_count: got %0d expected 3", val_q.size());
    end
    if (val_q.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        tests_run++;
        if (val_q[i] !== dc_exp[i]) begin
          tests_failed++; $display("FAIL dc_val[%0d]: got %0d expected %0d", i, $signed(val_q[i]), dc_exp[i]);
        end
      end
      tests_run++;
      if (vcyc_q[0] - tick_cyc_q[4*R-1] != 3) begin
        tests_failed++; $display("FAIL dc_latency: got %0d expected 3", vcyc_q[0] - tick_cyc_q[4*R-1]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef PDM_CIC_DC_BLOCK_EN
    test_dc_block();
`else
    test_const_one();
    test_const_zero();
    test_alternating();
    test_random_fast();
`endif
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
